// File: rtl/fpu_ss_result_arbiter.sv
// fpu_ss_result_arbiter
// Merges write-back results from NUM_SRC producers onto one core-facing result
// channel. Each source owns a DEPTH-entry FIFO; heads are drained one per cycle
// with round-robin fairness. Queued entries can be cancelled by a commit-kill
// (id + core_id match) until they are presented to the core.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   src_valid_i/src_ready_o  per-source push handshake (ready = FIFO not full)
//   src_*_i                  per-source payload, source i at slice i
//   kill_valid_i/kill_*_i    commit-kill strobe with id and core to cancel
//   result_valid_o/ready_i   output handshake
//   result_*_o               granted entry fields (zero when not valid)
//   result_src_o             index of the granted source
//   busy_o                   any FIFO holds an entry
module fpu_ss_result_arbiter #(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CORE_ID_WIDTH = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_SRC-1:0]                     src_valid_i,
    output logic [NUM_SRC-1:0]                     src_ready_o,
    input  logic [NUM_SRC*ID_WIDTH-1:0]            src_id_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]          src_data_i,
    input  logic [NUM_SRC*5-1:0]                   src_rd_i,
    input  logic [NUM_SRC-1:0]                     src_we_i,
    input  logic [NUM_SRC*CORE_ID_WIDTH-1:0]       src_core_id_i,
    input  logic [NUM_SRC-1:0]                     src_exc_i,
    input  logic [NUM_SRC*6-1:0]                   src_exccode_i,
    input  logic                                   kill_valid_i,
    input  logic [ID_WIDTH-1:0]                    kill_id_i,
    input  logic [CORE_ID_WIDTH-1:0]               kill_core_id_i,
    output logic                                   result_valid_o,
    input  logic                                   result_ready_i,
    output logic [ID_WIDTH-1:0]                    result_id_o,
    output logic [DATA_WIDTH-1:0]                  result_data_o,
    output logic [4:0]                             result_rd_o,
    output logic                                   result_we_o,
    output logic [CORE_ID_WIDTH-1:0]               result_core_id_o,
    output logic                                   result_exc_o,
    output logic [5:0]                             result_exccode_o,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] result_src_o,
    output logic                                   busy_o
);

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage, one row per source
    logic [ID_WIDTH-1:0]      id_q      [NUM_SRC][DEPTH];
    logic [DATA_WIDTH-1:0]    data_q    [NUM_SRC][DEPTH];
    logic [4:0]               rd_q      [NUM_SRC][DEPTH];
    logic                     we_q      [NUM_SRC][DEPTH];
    logic [CORE_ID_WIDTH-1:0] core_id_q [NUM_SRC][DEPTH];
    logic                     exc_q     [NUM_SRC][DEPTH];
    logic [5:0]               exccode_q [NUM_SRC][DEPTH];
    logic                     alive_q   [NUM_SRC][DEPTH];

    logic [PTR_W-1:0] wptr_q [NUM_SRC];
    logic [PTR_W-1:0] rptr_q [NUM_SRC];
    logic [CNT_W-1:0] cnt_q  [NUM_SRC];

    logic [SRC_W-1:0] rr_q;
    logic [SRC_W-1:0] grant_q;
    logic             lock_q;

    logic [NUM_SRC-1:0] head_alive;
    logic [NUM_SRC-1:0] drop;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] push_kill;
    logic [NUM_SRC-1:0] pop;
    logic [SRC_W-1:0]   rr_grant;
    logic               rr_found;
    logic [SRC_W-1:0]   idx_s;
    logic [SRC_W-1:0]   grant;
    logic               handshake;

    // Per-FIFO status: accept, occupancy, head liveness, push-time kill match
    always_comb begin
        head_alive  = '0;
        drop        = '0;
        push        = '0;
        push_kill   = '0;
        src_ready_o = '0;
        busy_o      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready_o[i] = (cnt_q[i] < CNT_W'(DEPTH));
            busy_o         = busy_o | (cnt_q[i] != '0);
            head_alive[i]  = (cnt_q[i] != '0) && alive_q[i][rptr_q[i]];
            // a dead head is never granted, so it can never be the presented entry
            drop[i]        = (cnt_q[i] != '0) && !alive_q[i][rptr_q[i]];
            push[i]        = src_valid_i[i] && src_ready_o[i];
            push_kill[i]   = kill_valid_i
                          && (src_id_i[i*ID_WIDTH +: ID_WIDTH] == kill_id_i)
                          && (src_core_id_i[i*CORE_ID_WIDTH +: CORE_ID_WIDTH] == kill_core_id_i);
        end
    end

    // Round-robin pick among alive heads; a stalled grant is held via lock_q
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        idx_s    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_s = SRC_W'((32'(rr_q) + 32'(k)) % NUM_SRC);
            if (!rr_found && head_alive[idx_s]) begin
                rr_found = 1'b1;
                rr_grant = idx_s;
            end
        end
        grant          = lock_q ? grant_q : rr_grant;
        result_valid_o = lock_q | rr_found;
        handshake      = result_valid_o & result_ready_i;
        pop            = '0;
        if (handshake) begin
            pop[grant] = 1'b1;
        end
    end

    // Result fields from the granted head, zeroed when idle
    always_comb begin
        result_src_o     = '0;
        result_id_o      = '0;
        result_data_o    = '0;
        result_rd_o      = '0;
        result_we_o      = 1'b0;
        result_core_id_o = '0;
        result_exc_o     = 1'b0;
        result_exccode_o = '0;
        if (result_valid_o) begin
            result_src_o     = grant;
            result_id_o      = id_q[grant][rptr_q[grant]];
            result_data_o    = data_q[grant][rptr_q[grant]];
            result_rd_o      = rd_q[grant][rptr_q[grant]];
            result_we_o      = we_q[grant][rptr_q[grant]];
            result_core_id_o = core_id_q[grant][rptr_q[grant]];
            result_exc_o     = exc_q[grant][rptr_q[grant]];
            result_exccode_o = exccode_q[grant][rptr_q[grant]];
        end
    end

    // FIFO, kill, round-robin and lock state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    id_q[i][j]      <= '0;
                    data_q[i][j]    <= '0;
                    rd_q[i][j]      <= '0;
                    we_q[i][j]      <= 1'b0;
                    core_id_q[i][j] <= '0;
                    exc_q[i][j]     <= 1'b0;
                    exccode_q[i][j] <= '0;
                    alive_q[i][j]   <= 1'b0;
                end
            end
            rr_q    <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                // kill spares the entry currently on the result channel
                if (kill_valid_i) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if ((id_q[i][j] == kill_id_i) && (core_id_q[i][j] == kill_core_id_i)
                            && !(result_valid_o && (grant == SRC_W'(i))
                                 && (rptr_q[i] == PTR_W'(j)))) begin
                            alive_q[i][j] <= 1'b0;
                        end
                    end
                end
                // push is written last so it overrides a kill on the same slot
                if (push[i]) begin
                    id_q[i][wptr_q[i]]      <= src_id_i[i*ID_WIDTH +: ID_WIDTH];
                    data_q[i][wptr_q[i]]    <= src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    rd_q[i][wptr_q[i]]      <= src_rd_i[i*5 +: 5];
                    we_q[i][wptr_q[i]]      <= src_we_i[i];
                    core_id_q[i][wptr_q[i]] <= src_core_id_i[i*CORE_ID_WIDTH +: CORE_ID_WIDTH];
                    exc_q[i][wptr_q[i]]     <= src_exc_i[i];
                    exccode_q[i][wptr_q[i]] <= src_exccode_i[i*6 +: 6];
                    alive_q[i][wptr_q[i]]   <= !push_kill[i];
                    wptr_q[i]               <= wptr_q[i] + 1'b1;
                end
                if (pop[i] || drop[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                if (push[i] && !(pop[i] || drop[i])) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (!push[i] && (pop[i] || drop[i])) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            lock_q  <= result_valid_o & ~result_ready_i;
            grant_q <= grant;
            if (handshake) begin
                rr_q <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : SRC_W'(grant + 1'b1);
            end
        end
    end

endmodule
